tsc_sd_receiver: RTL and testbench
==================================

// Module: tsc_sd_receiver
// PURPOSE
//   Receives the TSC serial-data (sd) stream and rebuilds the trigger-buffer bytes.
//   Frame: marker (sd rises from low and stays high for >=1 cycle), then BYTES bytes.
//   Each byte: start bit (0), 8 data bits MSB-first, stop bit (1), one bit per clk.
//   Bytes go out as single-cycle strobes and into a BYTES-deep readback buffer for host/bench readout.
// PARAMETERS
//   BYTES    32    bytes per frame (>=2)
//   TIMEOUT  1024  max consecutive high cycles while awaiting a start bit; 0 = disabled
//   IDXW     $clog2(BYTES)  index/address width (derived, not overridden)
// PORTS
//   clk         in   1     system clock; all sampling on rising edge
//   reset       in   1     asynchronous, active-low reset
//   sd          in   1     serial data from TSC, synchronous to clk (no synchroniser)
//   byte_data   out  8     last received byte
//   byte_valid  out  1     1-cycle strobe: byte_data/byte_idx valid
//   byte_idx    out  IDXW  position of byte_data in frame (0..BYTES-1)
//   frame_done  out  1     1-cycle strobe: all BYTES bytes received with good stop bits
//   frame_valid out  1     high from frame_done until next marker accepted
//   frame_err   out  1     1-cycle strobe: bad stop bit or timeout; frame discarded
//   busy        out  1     high in any state other than IDLE
//   rd_addr     in   IDXW  buffer read address
//   rd_data     out  8     buffer[rd_addr], registered, 1-cycle latency; 0 if rd_addr>=BYTES
// BEHAVIOUR
//   Reset (async assert, sync deassert by clk):
//   - state=IDLE; sd_q (previous-sd register) <= 1; all outputs 0; buffer cleared to 0.
//   States:
//   - IDLE: when sd=1 and sd_q=0 -> MARK; clear byte count and timeout counter; frame_valid<=0.
//     The sd_q reset value of 1 means a line held high at reset release must fall before a frame can start.
//   - MARK: sd=1 increments timeout counter; sd=0 (start bit) -> DATA, bit_cnt=0.
//     Counter reaching TIMEOUT -> frame_err strobe, go to IDLE. Counter clears on entry to MARK.
//   - DATA: shreg <= {shreg[6:0], sd} on each of 8 edges; after the 8th -> STOP. No timeout in DATA.
//   - STOP, sd=1: byte_data<=shreg; byte_idx<=count; byte_valid strobe; buffer[count]<=shreg.
//     If count==BYTES-1: frame_done strobe, frame_valid<=1, go to IDLE.
//     Otherwise count++ and go to MARK. Extra high cycles after the stop bit are idle time.
//   - STOP, sd=0: frame_err strobe, go to IDLE. byte_valid is not asserted.
//     Bytes already written to the buffer keep their values; frame_valid stays 0.
//   Latency:
//   - byte_valid, frame_done and frame_err are registered at the edge that samples the stop bit
//     (or the edge that hits the timeout). They are visible in the following cycle, for exactly one cycle.
//   - Minimum byte period is 10 clk (start + 8 data + stop). A new start bit is accepted on the cycle
//     right after the stop bit.
//   Boundaries:
//   - After frame_done, sd must return low before a new frame; IDLE only starts on a rising edge.
//   - A buffer read of the address being written in the same cycle returns the old data.
//   - sd activity in IDLE without a rising edge is ignored.
//   - frame_err and frame_done are never high in the same cycle.
//   - Reset mid-frame aborts immediately; no strobes are issued.
// TESTING
//   1 Marker (3 cyc high), 32 bytes 0x00..0x1F, 1 stop each -> 32 byte_valid with idx=value,
//     one frame_done, frame_valid=1, rd_addr=5 -> rd_data=0x05 next cycle.
//   2 Byte 0xA5 sent as bits 1,0,1,0,0,1,0,1 -> byte_data=0xA5, first byte_valid 10 cycles after start bit.
//   3 Stop bit of byte 3 driven 0 -> frame_err once, no 4th byte_valid, no frame_done, frame_valid=0.
//   4 Marker held high 1024 cycles -> frame_err on 1024th MARK cycle, busy=0 afterwards.
//     Repeat with TIMEOUT=0 -> no error.
//   5 sd high at reset release -> no frame start. Then sd low 2 cyc, high, valid frame -> received normally.
//   6 reset asserted mid-DATA of byte 10 -> outputs 0 asynchronously. A following full frame -> correct
//     frame_done; inter-byte idle of 5 high cycles accepted.

Source files
------------

// File: rtl/tsc_sd_receiver.sv
// ---------------------------------------------------------------------------
// tsc_sd_receiver
//   Rebuilds the trigger-buffer bytes sent by the TSC on its serial-data line.
//   A frame is a marker (sd rises and stays high >= 1 cycle) followed by
//   BYTES bytes. Each byte is one start bit (0), 8 data bits MSB first and one
//   stop bit (1), one bit per clk. Extra high cycles between bytes are idle.
//   Received bytes are issued as single-cycle strobes and stored in a
//   BYTES-deep readback buffer.
//
// Handshake: there is no back-pressure. byte_valid, frame_done and frame_err
//   are one-cycle strobes raised in the cycle after the edge that sampled the
//   stop bit (or hit the marker timeout); the consumer must take them then.
//
// Ports
//   clk         in   system clock, rising-edge sampling
//   reset       in   asynchronous active-low reset
//   sd          in   serial data, already synchronous to clk
//   byte_data   out  last received byte
//   byte_valid  out  strobe: byte_data / byte_idx valid
//   byte_idx    out  position of byte_data in the frame
//   frame_done  out  strobe: whole frame received with good stop bits
//   frame_valid out  high from frame_done until the next marker is accepted
//   frame_err   out  strobe: bad stop bit or marker timeout, frame dropped
//   busy        out  high whenever the FSM is not in IDLE
//   rd_addr     in   readback buffer address
//   rd_data     out  buffer[rd_addr], registered; 0 when rd_addr >= BYTES
//   dbg_state   out  current FSM state (0 IDLE, 1 MARK, 2 DATA, 3 STOP)
// ---------------------------------------------------------------------------
module tsc_sd_receiver #(
    parameter int BYTES   = 32,
    parameter int TIMEOUT = 1024,
    localparam int IDXW   = $clog2(BYTES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sd,
    output logic [7:0]      byte_data,
    output logic            byte_valid,
    output logic [IDXW-1:0] byte_idx,
    output logic            frame_done,
    output logic            frame_valid,
    output logic            frame_err,
    output logic            busy,
    input  logic [IDXW-1:0] rd_addr,
    output logic [7:0]      rd_data,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        DATA = 2'd2,
        STOP = 2'd3
    } state_t;

    // Timeout counter only needs to reach TIMEOUT; keep at least one bit so
    // the disabled (TIMEOUT = 0) build still elaborates cleanly.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(BYTES - 1);
    localparam logic [IDXW:0]   RD_LIM   = (IDXW + 1)'(BYTES);

    state_t          r_state;
    logic            r_sd_q;
    logic [TW-1:0]   r_to_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic [IDXW-1:0] r_count;
    logic [7:0]      r_buf [BYTES];

    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            // Reset to 1 so a line already high at release is not a marker.
            r_sd_q      <= 1'b1;
            r_to_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_count     <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            byte_idx    <= '0;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            rd_data     <= '0;
            for (int i = 0; i < BYTES; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_sd_q     <= sd;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            // Non-blocking read: a same-cycle write to this address is seen
            // on the next read, so the old data comes back here.
            if ({1'b0, rd_addr} < RD_LIM) begin
                rd_data <= r_buf[rd_addr];
            end else begin
                rd_data <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (sd && !r_sd_q) begin
                        r_state     <= MARK;
                        r_count     <= '0;
                        r_to_cnt    <= '0;
                        frame_valid <= 1'b0;
                    end
                end

                MARK: begin
                    if (!sd) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        if (r_to_cnt == TO_LAST) begin
                            frame_err <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    r_shreg   <= {r_shreg[6:0], sd};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    if (sd) begin
                        byte_data        <= r_shreg;
                        byte_idx         <= r_count;
                        byte_valid       <= 1'b1;
                        r_buf[r_count]   <= r_shreg;
                        if (r_count == IDX_LAST) begin
                            frame_done  <= 1'b1;
                            frame_valid <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_count  <= r_count + 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= MARK;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tsc_sd_receiver.sv
// Directed bench for tsc_sd_receiver. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_tsc_sd_receiver;

    localparam int BYTES = 32;
    localparam int IDXW  = $clog2(BYTES);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sd = 1'b0;
    logic [IDXW-1:0] rd_addr = '0;

    always #5 clk = ~clk;

    // main DUT (TIMEOUT = 1024)
    logic [7:0]      byte_data;
    logic            byte_valid;
    logic [IDXW-1:0] byte_idx;
    logic            frame_done, frame_valid, frame_err, busy;
    logic [7:0]      rd_data;
    logic [1:0]      dbg_state;

    tsc_sd_receiver #(.BYTES(BYTES), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .sd(sd),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_idx(byte_idx),
        .frame_done(frame_done), .frame_valid(frame_valid), .frame_err(frame_err),
        .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
    );

    // second DUT with the timeout disabled, same stimulus
    logic [7:0]      nt_byte_data;
    logic            nt_byte_valid;
    logic [IDXW-1:0] nt_byte_idx;
    logic            nt_frame_done, nt_frame_valid, nt_frame_err, nt_busy;
    logic [7:0]      nt_rd_data;
    logic [1:0]      nt_dbg_state;

    tsc_sd_receiver #(.BYTES(BYTES), .TIMEOUT(0)) dut_nt (
        .clk(clk), .reset(reset), .sd(sd),
        .byte_data(nt_byte_data), .byte_valid(nt_byte_valid), .byte_idx(nt_byte_idx),
        .frame_done(nt_frame_done), .frame_valid(nt_frame_valid), .frame_err(nt_frame_err),
        .busy(nt_busy), .rd_addr(rd_addr), .rd_data(nt_rd_data), .dbg_state(nt_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];
    int byte_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int nt_err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (byte_valid) begin
            byte_cnt++;
            check("byte_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("byte", {16'd0, 8'(byte_idx), byte_data}, {16'd0, exp_q.pop_front()});
            end
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if (frame_done || frame_err) begin
            check("done_err_excl", {31'd0, frame_done & frame_err}, 32'd0);
        end
        if (nt_frame_err) nt_err_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        @(negedge clk);
        sd = b;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx, input logic stop);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        if (stop) exp_q.push_back({8'(idx), b});
        send_bit(stop);
    endtask

    // marker of mlen high cycles, then BYTES bytes of base + i*step,
    // gap extra high cycles after every stop bit except the last
    task automatic send_frame(input int mlen, input logic [7:0] base,
                              input logic [7:0] step, input int gap);
        send_bit(1'b0);
        send_bit(1'b0);
        repeat (mlen) send_bit(1'b1);
        for (int i = 0; i < BYTES; i++) begin
            send_byte(8'(base + 8'(i) * step), i, 1'b1);
            if (i != BYTES - 1) repeat (gap) send_bit(1'b1);
        end
        send_bit(1'b0);
        send_bit(1'b0);
    endtask

    task automatic do_reset(input logic level);
        @(negedge clk);
        sd = level;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        byte_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
        nt_err_cnt = 0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    initial begin
        // ---- reset state ----
        do_reset(1'b0);
        check("rst_byte_data", {24'd0, byte_data}, 32'd0);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_byte_idx", 32'(byte_idx), 32'd0);
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // ---- test 1: 32 bytes 0x00..0x1F ----
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t1_mark_state", 32'(dbg_state), 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_bit(1'b1);
        for (int i = 0; i < BYTES; i++) begin
            send_byte(8'(i), i, 1'b1);
        end
        send_bit(1'b0);
        send_bit(1'b0);
        check("t1_bytes", 32'(byte_cnt), 32'd32);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_err", 32'(err_cnt), 32'd0);
        check("t1_frame_valid", {31'd0, frame_valid}, 32'd1);
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);
        rd_addr = 5'd5;
        @(negedge clk);
        check("t1_rd5", {24'd0, rd_data}, 32'h05);
        rd_addr = 5'd31;
        @(negedge clk);
        check("t1_rd31", {24'd0, rd_data}, 32'h1F);
        rd_addr = '0;

        // ---- test 2: 0xA5 latency ----
        do_reset(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);                    // start bit
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        exp_q.push_back({8'd0, 8'hA5});
        send_bit(1'b1);                    // stop bit, 9 cycles after start
        check("t2_not_early", {31'd0, byte_valid}, 32'd0);
        @(negedge clk);                    // 10 cycles after start
        check("t2_valid", {31'd0, byte_valid}, 32'd1);
        check("t2_data", {24'd0, byte_data}, 32'hA5);
        @(negedge clk);
        check("t2_strobe_1cyc", {31'd0, byte_valid}, 32'd0);

        // ---- test 3: bad stop bit on byte 3 ----
        do_reset(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_byte(8'h10, 0, 1'b1);
        send_byte(8'h11, 1, 1'b1);
        send_byte(8'h12, 2, 1'b1);
        send_byte(8'h13, 3, 1'b0);
        repeat (3) send_bit(1'b0);
        check("t3_err", 32'(err_cnt), 32'd1);
        check("t3_bytes", 32'(byte_cnt), 32'd3);
        check("t3_done", 32'(done_cnt), 32'd0);
        check("t3_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        rd_addr = 5'd2;
        @(negedge clk);
        check("t3_rd2_kept", {24'd0, rd_data}, 32'h12);
        rd_addr = 5'd3;
        @(negedge clk);
        check("t3_rd3_unwritten", {24'd0, rd_data}, 32'h00);
        rd_addr = '0;

        // ---- test 4: marker timeout ----
        do_reset(1'b0);
        send_bit(1'b1);                    // rise sampled in IDLE
        repeat (1024) @(negedge clk);      // 1023 MARK cycles so far
        check("t4_no_err_yet", 32'(err_cnt), 32'd0);
        check("t4_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);                    // 1024th MARK cycle sampled
        check("t4_err", {31'd0, frame_err}, 32'd1);
        check("t4_busy_after", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check("t4_err_once", 32'(err_cnt), 32'd1);
        check("t4_nt_no_err", 32'(nt_err_cnt), 32'd0);
        check("t4_nt_busy", {31'd0, nt_busy}, 32'd1);

        // ---- test 5: sd high at reset release ----
        do_reset(1'b1);
        repeat (5) send_bit(1'b1);
        check("t5_idle", {31'd0, busy}, 32'd0);
        send_frame(1, 8'h03, 8'h07, 0);
        check("t5_bytes", 32'(byte_cnt), 32'd32);
        check("t5_done", 32'(done_cnt), 32'd1);
        check("t5_frame_valid", {31'd0, frame_valid}, 32'd1);
        rd_addr = 5'd4;
        @(negedge clk);
        check("t5_rd4", {24'd0, rd_data}, 32'h1F);
        rd_addr = '0;

        // ---- test 6: reset mid-DATA of byte 10 ----
        do_reset(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i), i, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("t6_pre_idx", 32'(byte_idx), 32'd9);
        check("t6_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_data", {24'd0, byte_data}, 32'd0);
        check("t6_async_idx", 32'(byte_idx), 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        check("t6_no_strobe", 32'(err_cnt + done_cnt), 32'd0);
        sd = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        byte_cnt = 0;
        @(negedge clk);
        send_frame(2, 8'h40, 8'h03, 5);
        check("t6_bytes", 32'(byte_cnt), 32'd32);
        check("t6_done", 32'(done_cnt), 32'd1);
        check("t6_err", 32'(err_cnt), 32'd0);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
